// File: rtl/or_bit_sequencer.sv
// or_bit_sequencer: serial controller for the single-bit OR datapath.
// Accepts an operand pair, walks it LSB first presenting a[k] | b[k] on c with
// its index, then holds the full OR mask and any-bit flag until the consumer
// takes it.
// Optional feature macro: OR_SEQ_HIT_COUNT_EN builds the saturating hit counter
// behind hit_count. When it is undefined, hit_count is tied to 0.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// SHIFT | one bit pair per cycle on c, bit_idx = current index
// DONE  | result held on result_* until out_ready

module or_bit_sequencer #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             c,
  output logic             c_valid,
  output logic [CW-1:0]    bit_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_mask,
  output logic             result_any,
  output logic [CW-1:0]    hit_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] IDX_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             c_bit;
  logic             accept;

  assign c_bit  = sa_q[0] | sb_q[0];
  assign accept = (state_q == IDLE) && in_valid;

  // State and datapath registers; reset discards any in-flight pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and datapath update: latch on accept, shift one bit per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sa_d    = a;
          sb_d    = b;
          mask_d  = '0;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (idx_q == CW'(i)) mask_d[i] = c_bit;
        end
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        idx_d = idx_q + CW'(1);
        if (idx_q == IDX_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef OR_SEQ_HIT_COUNT_EN
  localparam logic [CW-1:0] HIT_MAX = CW'(WIDTH);

  logic [CW-1:0] hit_q, hit_d;

  // Hit counter register.
  always_ff @(posedge clk) begin
    if (rst) hit_q <= '0;
    else     hit_q <= hit_d;
  end

  // Count c=1 cycles of the current pair, saturating at WIDTH.
  always_comb begin
    hit_d = hit_q;
    if (accept) begin
      hit_d = '0;
    end else if ((state_q == SHIFT) && c_bit && (hit_q != HIT_MAX)) begin
      hit_d = hit_q + CW'(1);
    end
  end

  assign hit_count = out_valid ? hit_q : '0;
`else
  assign hit_count = '0;
`endif

  // Handshake and result outputs; result ports only show data while DONE.
  always_comb begin
    in_ready    = (state_q == IDLE);
    busy        = (state_q != IDLE);
    c_valid     = (state_q == SHIFT);
    c           = c_valid & c_bit;
    bit_idx     = c_valid ? idx_q : '0;
    out_valid   = (state_q == DONE);
    result_mask = out_valid ? mask_q : '0;
    result_any  = out_valid & (|mask_q);
  end

endmodule

// File: tb/tb_or_bit_sequencer.sv
// Self-checking bench for or_bit_sequencer (WIDTH=8), reference model uses
// plain a|b and $countones.
module tb_or_bit_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic          c, c_valid;
  logic [CW-1:0] bit_idx;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result_mask;
  logic          result_any;
  logic [CW-1:0] hit_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  or_bit_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .c_valid(c_valid), .bit_idx(bit_idx),
    .out_valid(out_valid), .out_ready(out_ready), .result_mask(result_mask),
    .result_any(result_any), .hit_count(hit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] model_hits(input logic [W-1:0] m);
`ifdef OR_SEQ_HIT_COUNT_EN
    return CW'($countones(m));
`else
    return '0;
`endif
  endfunction

  // Offers one pair, records what the DUT shows, then releases the result.
  task automatic drive_pair(input logic [W-1:0] pa, input logic [W-1:0] pb,
                            output logic [W-1:0] c_seen, output int ncv,
                            output bit idx_ok, output int lat,
                            output logic [W-1:0] rmask, output logic rany,
                            output logic [CW-1:0] rhit, output logic idle_after);
    c_seen = '0; ncv = 0; idx_ok = 1'b1; lat = -1;
    rmask = '0; rany = 1'b0; rhit = '0;
    a = pa; b = pb; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int e = 0; e < 3 * W; e++) begin
      if (c_valid) begin
        if (int'(bit_idx) != e) idx_ok = 1'b0;
        c_seen[bit_idx[2:0]] = c;
        ncv++;
      end
      if (out_valid) begin
        lat = e; rmask = result_mask; rany = result_any; rhit = hit_count;
        break;
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    idle_after = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (c_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_c_valid got %b exp 0", c_valid); end
    n_checks++; if (c !== 1'b0)         begin n_fail++; $display("FAIL reset_c got %b exp 0", c); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (result_mask !== '0) begin n_fail++; $display("FAIL reset_mask got %h exp 00", result_mask); end
    n_checks++; if (result_any !== 1'b0) begin n_fail++; $display("FAIL reset_any got %b exp 0", result_any); end
    n_checks++; if (bit_idx !== '0)     begin n_fail++; $display("FAIL reset_bit_idx got %0d exp 0", bit_idx); end
    n_checks++; if (hit_count !== '0)   begin n_fail++; $display("FAIL reset_hit got %0d exp 0", hit_count); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic check_pair(input string tag, input logic [W-1:0] pa, input logic [W-1:0] pb);
    logic [W-1:0]  c_seen, rmask, exp_mask;
    logic [CW-1:0] rhit;
    logic          rany, idle_after;
    int            ncv, lat;
    bit            idx_ok;
    exp_mask = pa | pb;
    drive_pair(pa, pb, c_seen, ncv, idx_ok, lat, rmask, rany, rhit, idle_after);
    n_checks++; if (c_seen !== exp_mask) begin n_fail++; $display("FAIL %s_c_bits got %h exp %h", tag, c_seen, exp_mask); end
    n_checks++; if (ncv != W)            begin n_fail++; $display("FAIL %s_c_valid_cycles got %0d exp %0d", tag, ncv, W); end
    n_checks++; if (!idx_ok)             begin n_fail++; $display("FAIL %s_bit_idx_order got bad exp 0..%0d", tag, W - 1); end
    n_checks++; if (lat != W)            begin n_fail++; $display("FAIL %s_out_latency got %0d exp %0d", tag, lat, W); end
    n_checks++; if (rmask !== exp_mask)  begin n_fail++; $display("FAIL %s_mask got %h exp %h", tag, rmask, exp_mask); end
    n_checks++; if (rany !== (|exp_mask)) begin n_fail++; $display("FAIL %s_any got %b exp %b", tag, rany, |exp_mask); end
    n_checks++; if (rhit !== model_hits(exp_mask)) begin n_fail++; $display("FAIL %s_hit got %0d exp %0d", tag, rhit, model_hits(exp_mask)); end
    n_checks++; if (idle_after !== 1'b1) begin n_fail++; $display("FAIL %s_idle_after got %b exp 1", tag, idle_after); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4] = '{8'h75, 8'h00, 8'hFF, 8'h80};
    logic [W-1:0] vb [4] = '{8'h56, 8'h00, 8'hFF, 8'h01};
    for (int i = 0; i < 4; i++) check_pair($sformatf("vec%0d", i), va[i], vb[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) check_pair($sformatf("rnd%0d", i), W'($urandom), W'($urandom));
  endtask

  task automatic test_backpressure();
    int e;
    a = 8'h80; b = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (e = 0; e < 3 * W && !out_valid; e++) tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done got %b exp 1", out_valid); end
    a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", k, out_valid); end
      n_checks++; if (result_mask !== 8'h80) begin n_fail++; $display("FAIL bp_hold_mask cyc %0d got %h exp 80", k, result_mask); end
      n_checks++; if (in_ready !== 1'b0)     begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b exp 0", k, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_idle got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got %b exp 0", out_valid); end
    tick();
    in_valid = 1'b0;
    for (e = 0; e < 3 * W && !out_valid; e++) tick();
    n_checks++; if (result_mask !== 8'hFF) begin n_fail++; $display("FAIL bp_held_offer_mask got %h exp ff", result_mask); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    bit seen_valid = 1'b0;
    a = 8'hFF; b = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int e = 0; e < 3 * W && !(c_valid && bit_idx == 4'd3); e++) tick();
    n_checks++; if (bit_idx !== 4'd3) begin n_fail++; $display("FAIL mid_reach_idx3 got %0d exp 3", bit_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (c_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_c_valid got %b exp 0", c_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
    n_checks++; if (bit_idx !== '0)    begin n_fail++; $display("FAIL mid_bit_idx got %0d exp 0", bit_idx); end
    for (int e = 0; e < 2 * W; e++) begin
      if (out_valid) seen_valid = 1'b1;
      tick();
    end
    n_checks++; if (seen_valid) begin n_fail++; $display("FAIL mid_no_out_valid got 1 exp 0"); end
  endtask

  task automatic test_back_to_back();
    int           acc[$];
    logic [W-1:0] res[$];
    int           cyc = 0;
    bit           nxt;
    a = 8'hFF; b = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    while (res.size() < 2 && cyc < 60) begin
      if (out_valid) res.push_back(result_mask);
      nxt = in_ready && in_valid;
      tick();
      cyc++;
      if (nxt) begin
        acc.push_back(cyc);
        if (acc.size() == 1) begin a = 8'h01; b = 8'h02; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (acc.size() != 2) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 2", acc.size()); end
    else begin
      n_checks++; if (acc[1] - acc[0] != W + 2) begin n_fail++; $display("FAIL b2b_period got %0d exp %0d", acc[1] - acc[0], W + 2); end
    end
    n_checks++; if (res.size() != 2) begin n_fail++; $display("FAIL b2b_results got %0d exp 2", res.size()); end
    else begin
      n_checks++; if (res[0] !== 8'hFF) begin n_fail++; $display("FAIL b2b_res0 got %h exp ff", res[0]); end
      n_checks++; if (res[1] !== 8'h03) begin n_fail++; $display("FAIL b2b_res1 got %h exp 03", res[1]); end
    end
    tick();
  endtask

  task automatic test_operand_change();
    a = 8'h01; b = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    a = 8'hFF;
    for (int e = 0; e < 3 * W && !out_valid; e++) tick();
    n_checks++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL opchg_done got %b exp 1", out_valid); end
    n_checks++; if (result_mask !== 8'h01) begin n_fail++; $display("FAIL opchg_mask got %h exp 01", result_mask); end
    n_checks++; if (hit_count !== model_hits(8'h01)) begin n_fail++; $display("FAIL opchg_hit got %0d exp %0d", hit_count, model_hits(8'h01)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_operand_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
